// File: rtl/ifq_pkg.sv
// ifq_pkg
//   Shared types for the instruction fetch queue: FSM state encoding, the
//   queue entry layout {inst, len, pc} and the instruction-length clamp.
//   The entry widths are fixed here. A top-level parameter override must be
//   mirrored in these constants so that the entry layout still matches.
package ifq_pkg;

  localparam int IFQ_ADDR_W    = 12;
  localparam int IFQ_WORD_W    = 4;
  localparam int IFQ_MAX_WORDS = 4;
  localparam int IFQ_LEN_W     = $clog2(IFQ_MAX_WORDS + 1);
  localparam int IFQ_INST_W    = IFQ_MAX_WORDS * IFQ_WORD_W;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    PUSH
  } ifq_state_e;

  typedef struct packed {
    logic [IFQ_INST_W-1:0] inst;
    logic [IFQ_LEN_W-1:0]  len;
    logic [IFQ_ADDR_W-1:0] pc;
  } ifq_entry_t;

  // A zero length still costs one word. Lengths beyond the widest
  // instruction saturate.
  function automatic logic [IFQ_LEN_W-1:0] clamp_len(input logic [IFQ_LEN_W-1:0] len);
    if (len == '0) return IFQ_LEN_W'(1);
    if (len > IFQ_LEN_W'(IFQ_MAX_WORDS)) return IFQ_LEN_W'(IFQ_MAX_WORDS);
    return len;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo
//   Small register-based FIFO for assembled instructions.
//   Ports:
//     clk, reset   clock, synchronous active-high reset
//     push, din    write request and data (ignored when full without pop)
//     pop          read request (ignored when empty)
//     flush        empties the queue; takes priority over push and pop
//     full, empty  occupancy flags
//     head         registered entry at the read pointer
module ifq_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = logic
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  entry_t din,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Fetches variable-length instructions one ROM word at a time, assembles
//   them and queues {inst, len, pc} for a ready/valid consumer.
//   Optional build macro: IFQ_STALL_CNT_EN adds output stall_cnt[15:0], a
//   saturating count of cycles spent waiting in PUSH on a full queue.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     enable                fetch permitted
//     redirect, redirect_pc flush everything and restart at redirect_pc
//     rom_req, rom_addr     ROM read strobe and address
//     rom_data              ROM word, valid the cycle after rom_req
//     len_in                predecoded length of the word on rom_data
//     out_valid/out_ready   queue head handshake
//     out_inst/out_len/out_pc  registered queue head
//
//   state | meaning
//   IDLE  | waiting for enable
//   ADDR  | ROM read issued for pc
//   DATA  | capture ROM word into slot idx, advance pc
//   PUSH  | write assembled instruction, hold while queue full
module inst_fetch_queue
  import ifq_pkg::*;
#(
  parameter  int ADDR_W    = IFQ_ADDR_W,
  parameter  int WORD_W    = IFQ_WORD_W,
  parameter  int MAX_WORDS = IFQ_MAX_WORDS,
  parameter  int DEPTH     = 2,
  localparam int LEN_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        redirect,
  input  logic [ADDR_W-1:0]           redirect_pc,
  output logic                        rom_req,
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic [WORD_W-1:0]           rom_data,
  input  logic [LEN_W-1:0]            len_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [MAX_WORDS*WORD_W-1:0] out_inst,
  output logic [LEN_W-1:0]            out_len,
  output logic [ADDR_W-1:0]           out_pc
`ifdef IFQ_STALL_CNT_EN
  ,
  output logic [15:0]                 stall_cnt
`endif
);

  localparam int INST_W = MAX_WORDS * WORD_W;

  ifq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] start_pc_q, start_pc_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cur_len;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              push, pop, full, empty;
  ifq_entry_t        push_entry, head;

  // A redirect discards whatever the consumer would have taken this cycle.
  assign pop        = out_valid & out_ready & ~redirect;
  assign out_valid  = ~empty;
  assign push_entry = '{inst: inst_q, len: len_q, pc: start_pc_q};
  assign out_inst   = head.inst;
  assign out_len    = head.len;
  assign out_pc     = head.pc;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    start_pc_d = start_pc_q;
    idx_d      = idx_q;
    len_d      = len_q;
    inst_d     = inst_q;
    cur_len    = len_q;
    push       = 1'b0;
    rom_req    = 1'b0;
    rom_addr   = '0;
    case (state_q)
      IDLE: if (enable) state_d = ADDR;
      ADDR: begin
        rom_req  = 1'b1;
        rom_addr = pc_q;
        state_d  = DATA;
      end
      DATA: begin
        // Word 0 fixes the length and start pc, and zeroes the upper slots.
        if (idx_q == '0) begin
          cur_len    = clamp_len(len_in);
          len_d      = cur_len;
          start_pc_d = pc_q;
          inst_d     = '0;
        end
        inst_d[int'(idx_q)*WORD_W +: WORD_W] = rom_data;
        pc_d = pc_q + 1'b1;
        if (idx_q + 1'b1 == cur_len) begin
          state_d = PUSH;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ADDR;
        end
      end
      PUSH: begin
        if (!full || pop) begin
          push    = 1'b1;
          idx_d   = '0;
          state_d = enable ? ADDR : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect) begin
      state_d = IDLE;
      pc_d    = redirect_pc;
      idx_d   = '0;
      push    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      start_pc_q <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      inst_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      start_pc_q <= start_pc_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      inst_q     <= inst_d;
    end
  end

  ifq_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (ifq_entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (push_entry),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

`ifdef IFQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // In PUSH, no push without a redirect means the queue is full.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (redirect) stall_cnt_d = '0;
    else if (state_q == PUSH && !push && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;
  localparam int ADDR_W    = 12;
  localparam int WORD_W    = 4;
  localparam int MAX_WORDS = 4;
  localparam int DEPTH     = 2;
  localparam int LEN_W     = 3;

  logic              clk = 1'b0;
  logic              reset, enable, redirect, out_ready;
  logic [ADDR_W-1:0] redirect_pc;
  logic              rom_req, out_valid;
  logic [ADDR_W-1:0] rom_addr, out_pc;
  logic [WORD_W-1:0] rom_data = '0;
  logic [LEN_W-1:0]  len_in = '0;
  logic [15:0]       out_inst;
  logic [LEN_W-1:0]  out_len;
`ifdef IFQ_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0]  rom    [4096];
  logic [2:0]  lentab [4096];
  logic [11:0] addr_log [$];
  logic        rq = 1'b0;
  logic [11:0] ra = '0;

  always #5 clk = ~clk;

  inst_fetch_queue #(
    .ADDR_W(ADDR_W), .WORD_W(WORD_W), .MAX_WORDS(MAX_WORDS), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .redirect(redirect),
    .redirect_pc(redirect_pc), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_data(rom_data), .len_in(len_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_len(out_len), .out_pc(out_pc)
`ifdef IFQ_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // ROM model: request seen mid-cycle, word presented during the next cycle,
  // junk otherwise.
  always @(negedge clk) begin
    rq = (rom_req === 1'b1);
    ra = rom_addr;
    if (rom_req === 1'b1) addr_log.push_back(rom_addr);
  end

  always @(posedge clk) begin
    #1;
    if (rq) begin
      rom_data = rom[ra];
      len_in   = lentab[ra];
    end else begin
      rom_data = 4'($urandom);
      len_in   = 3'($urandom);
    end
  end

  // Reference: an instruction starting at p is clamp(lentab[p]) consecutive
  // ROM words, word k in nibble k.
  function automatic int model_len(int p);
    int l = int'(lentab[p % 4096]);
    if (l == 0) return 1;
    if (l > MAX_WORDS) return MAX_WORDS;
    return l;
  endfunction

  function automatic logic [15:0] model_inst(int p);
    logic [15:0] v = '0;
    int l = model_len(p);
    for (int k = 0; k < l; k++) v |= 16'(rom[(p + k) % 4096]) << (4 * k);
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; enable = 1'b0; redirect = 1'b0; out_ready = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_redirect(input logic [11:0] pc);
    @(negedge clk);
    redirect = 1'b1; redirect_pc = pc;
    @(negedge clk);
    redirect = 1'b0;
  endtask

  task automatic test_reset();
    int base;
    @(negedge clk);
    reset = 1'b1; redirect = 1'b1; redirect_pc = 12'h123; enable = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (rom_req !== 1'b0) begin n_fail++; $display("FAIL reset_rom_req got %b want 0", rom_req); end
    n_tests++; if (rom_addr !== 12'h000) begin n_fail++; $display("FAIL reset_rom_addr got %h want 000", rom_addr); end
    n_tests++; if (out_inst !== 16'h0000) begin n_fail++; $display("FAIL reset_out_inst got %h want 0000", out_inst); end
    n_tests++; if (out_len !== 3'd0) begin n_fail++; $display("FAIL reset_out_len got %0d want 0", out_len); end
    n_tests++; if (out_pc !== 12'h000) begin n_fail++; $display("FAIL reset_out_pc got %h want 000", out_pc); end
    base = addr_log.size();
    reset = 1'b0; redirect = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    n_tests++;
    if (addr_log.size() <= base || addr_log[base] !== 12'h000) begin
      n_fail++; $display("FAIL reset_over_redirect first rom_addr got %h want 000",
                         (addr_log.size() > base) ? addr_log[base] : 12'hxxx);
    end
  endtask

  task automatic test_basic();
    int base, cyc;
    rom[0] = 4'h5; lentab[0] = 3'd2; rom[1] = 4'hA;
    do_reset();
    base = addr_log.size();
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    n_tests++; if (cyc != 5) begin n_fail++; $display("FAIL basic_latency got %0d want 5", cyc); end
    n_tests++; if (out_inst !== 16'h00A5) begin n_fail++; $display("FAIL basic_out_inst got %h want 00a5", out_inst); end
    n_tests++; if (out_len !== 3'd2) begin n_fail++; $display("FAIL basic_out_len got %0d want 2", out_len); end
    n_tests++; if (out_pc !== 12'h000) begin n_fail++; $display("FAIL basic_out_pc got %h want 000", out_pc); end
    repeat (4) @(negedge clk);
    n_tests++;
    if (addr_log.size() != base + 2 || addr_log[base] !== 12'h000 || addr_log[base+1] !== 12'h001) begin
      n_fail++; $display("FAIL basic_addr_seq got %0d requests want 2 (000,001)", addr_log.size() - base);
    end
    n_tests++; if (rom_req !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after_disable rom_req got %b want 0", rom_req); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop_empty out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_full_stall();
    int base;
`ifdef IFQ_STALL_CNT_EN
    logic [15:0] s0;
`endif
    for (int i = 0; i < 16; i++) begin lentab[i] = 3'd1; rom[i] = 4'(i + 1); end
    do_reset();
    base = addr_log.size();
    enable = 1'b1; out_ready = 1'b0;
    repeat (15) @(negedge clk);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_out_valid got %b want 1", out_valid); end
    n_tests++; if (out_pc !== 12'h000 || out_inst !== 16'h0001) begin n_fail++; $display("FAIL full_head got pc %h inst %h want 000 0001", out_pc, out_inst); end
    n_tests++; if (addr_log.size() != base + 3) begin n_fail++; $display("FAIL full_fetch_count got %0d want 3", addr_log.size() - base); end
`ifdef IFQ_STALL_CNT_EN
    s0 = stall_cnt;
`endif
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++; if (rom_req !== 1'b0) begin n_fail++; $display("FAIL full_hold_rom_req cycle %0d got %b want 0", c, rom_req); end
    end
`ifdef IFQ_STALL_CNT_EN
    n_tests++; if (stall_cnt - s0 !== 16'd5) begin n_fail++; $display("FAIL stall_cnt_delta got %0d want 5", stall_cnt - s0); end
`endif
  endtask

  // Continues from the held-full state left by test_full_stall.
  task automatic test_simul_push_pop();
    int cnt;
    out_ready = 1'b1; enable = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    n_tests++; if (out_valid !== 1'b1 || out_pc !== 12'h001) begin n_fail++; $display("FAIL simul_head_advance got valid %b pc %h want 1 001", out_valid, out_pc); end
    cnt = 0;
    while (out_valid === 1'b1 && cnt < 10) begin
      n_tests++;
      if (out_pc !== 12'(cnt + 1) || out_inst !== 16'(cnt + 2)) begin
        n_fail++; $display("FAIL simul_drain_order entry %0d got pc %h inst %h want %h %h", cnt, out_pc, out_inst, 12'(cnt + 1), 16'(cnt + 2));
      end
      out_ready = 1'b1;
      @(negedge clk);
      cnt++;
    end
    out_ready = 1'b0;
    n_tests++; if (cnt != 2) begin n_fail++; $display("FAIL simul_count got %0d entries want 2", cnt); end
  endtask

  task automatic test_redirect();
    int base, cyc;
    bit found;
    lentab[0] = 3'd1; lentab[1] = 3'd2; lentab[12'h3F0] = 3'd1; rom[12'h3F0] = 4'hC;
    do_reset();
    enable = 1'b1; out_ready = 1'b0;
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (rom_req === 1'b1 && rom_addr === 12'h002) found = 1;
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL redirect_setup timeout got no request at 002 want one"); end
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 12'h3F0;
    @(negedge clk);
    redirect = 1'b0;
    base = addr_log.size();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_flush out_valid got %b want 0", out_valid); end
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 30) begin @(negedge clk); cyc++; end
    enable = 1'b0;
    n_tests++;
    if (addr_log.size() <= base || addr_log[base] !== 12'h3F0) begin
      n_fail++; $display("FAIL redirect_next_addr got %h want 3f0", (addr_log.size() > base) ? addr_log[base] : 12'hxxx);
    end
    n_tests++;
    if (out_pc !== 12'h3F0 || out_len !== 3'd1 || out_inst !== 16'h000C) begin
      n_fail++; $display("FAIL redirect_first_head got pc %h len %0d inst %h want 3f0 1 000c", out_pc, out_len, out_inst);
    end
  endtask

  task automatic test_wrap();
    int base, cyc;
    lentab[12'hFFF] = 3'd2; rom[12'hFFF] = 4'h3; rom[0] = 4'h9;
    do_reset();
    do_redirect(12'hFFF);
    base = addr_log.size();
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 30) begin @(negedge clk); cyc++; end
    n_tests++;
    if (addr_log.size() < base + 2 || addr_log[base] !== 12'hFFF || addr_log[base+1] !== 12'h000) begin
      n_fail++; $display("FAIL wrap_addr_seq got %0d requests want FFF then 000", addr_log.size() - base);
    end
    n_tests++;
    if (out_pc !== 12'hFFF || out_inst !== 16'h0093 || out_len !== 3'd2) begin
      n_fail++; $display("FAIL wrap_head got pc %h inst %h len %0d want fff 0093 2", out_pc, out_inst, out_len);
    end
  endtask

  task automatic test_len_clamp();
    int base, cyc;
    lentab[12'h100] = 3'd0; rom[12'h100] = 4'h6; lentab[12'h101] = 3'd7;
    for (int k = 0; k < 4; k++) rom[12'h101 + k] = 4'(k + 1);
    do_reset();
    do_redirect(12'h100);
    base = addr_log.size();
    enable = 1'b1;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 30) begin @(negedge clk); cyc++; end
    n_tests++;
    if (out_len !== 3'd1 || out_inst !== 16'h0006 || out_pc !== 12'h100) begin
      n_fail++; $display("FAIL len_zero got len %0d inst %h pc %h want 1 0006 100", out_len, out_inst, out_pc);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 30) begin @(negedge clk); cyc++; end
    enable = 1'b0;
    n_tests++;
    if (out_len !== 3'd4 || out_inst !== 16'h4321 || out_pc !== 12'h101) begin
      n_fail++; $display("FAIL len_clamp got len %0d inst %h pc %h want 4 4321 101", out_len, out_inst, out_pc);
    end
    for (int k = 1; k <= 4; k++) begin
      n_tests++;
      if (addr_log.size() <= base + k || addr_log[base+k] !== 12'(12'h100 + k)) begin
        n_fail++; $display("FAIL len_clamp_addr index %0d got %h want %h", k,
                           (addr_log.size() > base + k) ? addr_log[base+k] : 12'hxxx, 12'(12'h100 + k));
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] exp_fetch, exp_ipc;
    bit          prev_redir;
    int          npops, r;
    for (int i = 0; i < 4096; i++) begin
      rom[i] = 4'($urandom);
      r = $urandom_range(0, 9);
      lentab[i] = (r < 2) ? 3'd0 : (r > 7) ? 3'd7 : 3'($urandom_range(1, 4));
    end
    do_reset();
    exp_fetch = '0; exp_ipc = '0; prev_redir = 0; npops = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (prev_redir) begin
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_redirect_flush cycle %0d out_valid got %b want 0", c, out_valid); end
      end
      enable      = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      redirect    = ($urandom_range(0, 80) == 0);
      redirect_pc = 12'($urandom);
      if (rom_req === 1'b1) begin
        n_tests++;
        if (rom_addr !== exp_fetch) begin n_fail++; $display("FAIL rand_rom_addr cycle %0d got %h want %h", c, rom_addr, exp_fetch); end
        exp_fetch = exp_fetch + 1'b1;
      end
      if (out_valid === 1'b1 && out_ready && !redirect) begin
        n_tests++;
        if (out_pc !== exp_ipc || out_len !== 3'(model_len(int'(exp_ipc))) || out_inst !== model_inst(int'(exp_ipc))) begin
          n_fail++; $display("FAIL rand_pop cycle %0d got pc %h len %0d inst %h want %h %0d %h", c, out_pc, out_len, out_inst,
                             exp_ipc, model_len(int'(exp_ipc)), model_inst(int'(exp_ipc)));
        end
        exp_ipc = exp_ipc + 12'(model_len(int'(exp_ipc)));
        npops++;
      end
      if (redirect) begin
        exp_fetch = redirect_pc;
        exp_ipc   = redirect_pc;
      end
      prev_redir = redirect;
    end
    @(negedge clk);
    redirect = 1'b0; enable = 1'b0; out_ready = 1'b0;
    n_tests++; if (npops < 100) begin n_fail++; $display("FAIL rand_progress got %0d pops want at least 100", npops); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    for (int i = 0; i < 4096; i++) begin rom[i] = 4'($urandom); lentab[i] = 3'($urandom); end
    test_reset();
    test_basic();
    test_full_stall();
    test_simul_push_pop();
    test_redirect();
    test_wrap();
    test_len_clamp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
